// File: rtl/common_pkg.sv
// Shared machine-word type and helpers for the pipeline stages.
package common;

  typedef logic [63:0] word_t;

  function automatic word_t sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/pipeline_pkg.sv
// Inter-stage payloads, operation encoding and EX-stage FSM states.
package pipeline;
  import common::*;

  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE,
    OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_MULW,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
  } op_t;

  typedef struct packed {
    op_t  op;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    word_t       srca;
    word_t       srcb;
    word_t       rd;
    logic [4:0]  dst;
    logic [31:0] instr;
    logic [11:0] csr_addr;
    word_t       csr_data;
  } decode_data_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [4:0]  dst;
    logic [31:0] instr;
    word_t       aluout;
    word_t       rd;
    logic [11:0] csr_addr;
    word_t       csr_data;
  } exec_data_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} exec_state_t;

  function automatic logic is_muldiv(input op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_MULW,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_mul(input op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_MULW};
  endfunction

  function automatic logic is_word_div(input op_t op);
    return op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_signed_div(input op_t op);
    return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic logic is_rem(input op_t op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider on operand magnitudes; one quotient bit per cycle.
module div_unit
  import common::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  start,
  input  logic  is_signed,
  input  logic  is_word,
  input  word_t a,
  input  word_t b,
  output logic  done,
  output word_t quotient,
  output word_t remainder
);
  word_t       a_ext, b_ext, mag_a, mag_b;
  logic        a_neg, b_neg;
  word_t       quo, rem, dvs, quo_nx, rem_nx;
  logic [6:0]  count;
  logic        neg_q, neg_r, word_q, ge;
  logic [64:0] shifted, trial;
  logic [31:0] q32, r32;

  always_comb begin
    if (is_word) begin
      a_ext = is_signed ? sext32(a[31:0]) : {32'b0, a[31:0]};
      b_ext = is_signed ? sext32(b[31:0]) : {32'b0, b[31:0]};
    end else begin
      a_ext = a;
      b_ext = b;
    end
    a_neg = is_signed & a_ext[63];
    b_neg = is_signed & b_ext[63];
    mag_a = a_neg ? -a_ext : a_ext;
    mag_b = b_neg ? -b_ext : b_ext;
  end

  // rem < dvs always holds, so bit 64 of trial is a clean borrow flag.
  assign shifted = {rem, quo[63]};
  assign trial   = shifted - {1'b0, dvs};
  assign ge      = ~trial[64];
  assign rem_nx  = ge ? trial[63:0] : shifted[63:0];
  assign quo_nx  = {quo[62:0], ge};
  assign done    = (count == 7'd1);

  always_comb begin
    q32 = neg_q ? -quo_nx[31:0] : quo_nx[31:0];
    r32 = neg_r ? -rem_nx[31:0] : rem_nx[31:0];
    if (word_q) begin
      quotient  = sext32(q32);
      remainder = sext32(r32);
    end else begin
      quotient  = neg_q ? -quo_nx : quo_nx;
      remainder = neg_r ? -rem_nx : rem_nx;
    end
  end

  // Word ops park the dividend in the upper half so the same MSB-first shifter serves both widths.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      count  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      word_q <= 1'b0;
    end else if (start) begin
      quo    <= is_word ? {mag_a[31:0], 32'b0} : mag_a;
      rem    <= '0;
      dvs    <= mag_b;
      count  <= is_word ? 7'd32 : 7'd64;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      word_q <= is_word;
    end else if (count != '0) begin
      quo   <= quo_nx;
      rem   <= rem_nx;
      count <= count - 7'd1;
    end
  end

endmodule

// File: rtl/execute.sv
// EX stage: single-cycle ALU; define RV64M_EN to add the multi-cycle mul/div FSM.
module execute
  import common::*;
  import pipeline::*;
(
  input  logic         clk,
  input  logic         reset,
  input  decode_data_t dataD,
  output exec_data_t   dataE,
  output logic         readyE,
  input  logic         all_ready
);
  op_t   op;
  word_t a, b, alu_res, aluout;

  assign op = dataD.ctl.op;
  assign a  = dataD.srca;
  assign b  = dataD.srcb;

  always_comb begin
    alu_res = a + b;
    case (op)
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << b[5:0];
      OP_SRL:  alu_res = a >> b[5:0];
      OP_SRA:  alu_res = $signed(a) >>> b[5:0];
      OP_SLT:  alu_res = {63'b0, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {63'b0, a < b};
      OP_ADDW: alu_res = sext32(a[31:0] + b[31:0]);
      OP_SUBW: alu_res = sext32(a[31:0] - b[31:0]);
      OP_SLLW: alu_res = sext32(a[31:0] << b[4:0]);
      OP_SRLW: alu_res = sext32(a[31:0] >> b[4:0]);
      OP_SRAW: alu_res = sext32($signed(a[31:0]) >>> b[4:0]);
      default: alu_res = a + b;
    endcase
  end

`ifdef RV64M_EN
  exec_state_t  state, state_nx;
  word_t        result, mul_res, dvd, special, div_q, div_r;
  logic [127:0] prod;
  logic         md, mul_op, sgn_op, word_op, rem_op, b_zero, ovf, div_start, div_done, rem_sel;

  assign md      = is_muldiv(op);
  assign mul_op  = is_mul(op);
  assign sgn_op  = is_signed_div(op);
  assign word_op = is_word_div(op);
  assign rem_op  = is_rem(op);

  // One 128-bit multiplier; operand extension selects the signedness of each side.
  assign prod = {{64{a[63] & (op == OP_MULH || op == OP_MULHSU)}}, a}
              * {{64{b[63] & (op == OP_MULH)}}, b};

  always_comb begin
    case (op)
      OP_MUL:  mul_res = prod[63:0];
      OP_MULW: mul_res = sext32(prod[31:0]);
      default: mul_res = prod[127:64];
    endcase
  end

  assign dvd       = word_op ? sext32(a[31:0]) : a;
  assign b_zero    = word_op ? (b[31:0] == '0) : (b == '0);
  assign ovf       = sgn_op & (word_op ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                                       : (a == 64'h8000_0000_0000_0000 && b == '1));
  assign special   = b_zero ? (rem_op ? dvd : '1) : (rem_op ? '0 : dvd);
  assign div_start = (state == IDLE) && !all_ready && md && !mul_op && !b_zero && !ovf;

  div_unit u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .is_signed (sgn_op),
    .is_word   (word_op),
    .a         (a),
    .b         (b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (all_ready) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (md) state_nx = (mul_op || b_zero || ovf) ? DONE : BUSY;
        BUSY:    if (div_done) state_nx = DONE;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    readyE = 1'b1;
    aluout = alu_res;
    case (state)
      IDLE: if (md) begin
        readyE = 1'b0;
        aluout = '0;
      end
      BUSY: begin
        readyE = 1'b0;
        aluout = result;
      end
      DONE:    aluout = result;
      default: aluout = alu_res;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= '0;
      rem_sel <= 1'b0;
    end else if (state == IDLE && md && !all_ready) begin
      rem_sel <= rem_op;
      if (mul_op)              result <= mul_res;
      else if (b_zero || ovf)  result <= special;
    end else if (state == BUSY && div_done && !all_ready) begin
      result <= rem_sel ? div_r : div_q;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset ^ all_ready;
  assign readyE = 1'b1;
  assign aluout = is_muldiv(op) ? '0 : alu_res;
`endif

  always_comb begin
    dataE.ctl      = dataD.ctl;
    dataE.dst      = dataD.dst;
    dataE.instr    = dataD.instr;
    dataE.aluout   = aluout;
    dataE.rd       = dataD.rd;
    dataE.csr_addr = dataD.csr_addr;
    dataE.csr_data = dataD.csr_data;
  end

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for execute: expected aluout and latency queued at issue, checked at readyE.
module tb_execute;
  import common::*;
  import pipeline::*;

`ifdef RV64M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    word_t       val;
    int unsigned lat;
    logic [31:0] instr;
    word_t       rd;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         all_ready;
  logic         readyE;
  decode_data_t dataD;
  exec_data_t   dataE;
  exp_t         sb[$];
  int unsigned  total = 0;
  int unsigned  bad = 0;

  execute dut (
    .clk       (clk),
    .reset     (reset),
    .dataD     (dataD),
    .dataE     (dataE),
    .readyE    (readyE),
    .all_ready (all_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t got, input word_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input op_t op, input word_t a, input word_t b,
                        input word_t exp_v, input int unsigned exp_lat, input bit md,
                        input bit scramble);
    exp_t        e;
    int unsigned cyc = 0;
    bit          got = 1'b0;
    @(posedge clk); #1;
    dataD.ctl.op = op;
    dataD.srca   = a;
    dataD.srcb   = b;
    dataD.instr  = $urandom;
    dataD.rd     = {$urandom, $urandom};
    dataD.dst    = 5'($urandom);
    all_ready    = 1'b0;
    sb.push_back('{tag: tag, val: (md && !M_EN) ? 64'd0 : exp_v,
                   lat: (md && !M_EN) ? 0 : exp_lat, instr: dataD.instr, rd: dataD.rd});
    while (!got && cyc <= 200) begin
      @(negedge clk);
      if (readyE) got = 1'b1;
      else begin
        cyc++;
        if (scramble && cyc == 3) begin
          dataD.srca = ~a;
          dataD.srcb = 64'd1;
        end
      end
    end
    e = sb.pop_front();
    check({tag, "_val"}, dataE.aluout, e.val);
    check({tag, "_lat"}, word_t'(cyc), word_t'(e.lat));
    check({tag, "_instr"}, word_t'(dataE.instr), word_t'(e.instr));
    check({tag, "_rd"}, dataE.rd, e.rd);
    all_ready = 1'b1;
    @(posedge clk); #1;
    all_ready    = 1'b0;
    dataD.ctl.op = OP_ADD;
  endtask

  initial begin
    reset        = 1'b1;
    all_ready    = 1'b0;
    dataD        = '0;
    dataD.ctl.op = OP_DIV;
    dataD.srca   = 64'd100;
    dataD.srcb   = 64'd7;
    #12;
    check("rst_ready", word_t'(readyE), M_EN ? 64'd0 : 64'd1);
    check("rst_aluout", dataE.aluout, 64'd0);
    dataD.ctl.op = OP_ADD;
    @(negedge clk);
    reset = 1'b0;

    run_op("add",    OP_ADD,  64'd5, -64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
    run_op("sub",    OP_SUB,  64'd3, 64'd10, 64'hFFFF_FFFF_FFFF_FFF9, 0, 0, 0);
    run_op("xor",    OP_XOR,  64'hF0F0, 64'hFF00, 64'h0FF0, 0, 0, 0);
    run_op("sra",    OP_SRA,  64'h8000_0000_0000_0000, 64'd68, 64'hF800_0000_0000_0000, 0, 0, 0);
    run_op("srlw",   OP_SRLW, 64'hFFFF_FFFF_8000_0000, 64'd36, 64'h0000_0000_0800_0000, 0, 0, 0);
    run_op("sraw",   OP_SRAW, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 0, 0, 0);
    run_op("slt",    OP_SLT,  -64'd1, 64'd1, 64'd1, 0, 0, 0);
    run_op("sltu",   OP_SLTU, -64'd1, 64'd1, 64'd0, 0, 0, 0);
    run_op("addw",   OP_ADDW, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 0, 0, 0);
    run_op("sllw",   OP_SLLW, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000, 0, 0, 0);
    run_op("load",   OP_LOAD, 64'h1000, 64'd8, 64'h1008, 0, 0, 0);

    run_op("div",    OP_DIV,  64'd100, 64'd7, 64'd14, 65, 1, 1);
    run_op("rem",    OP_REM,  64'd100, 64'd7, 64'd2, 65, 1, 0);
    run_op("divneg", OP_DIV,  -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65, 1, 0);
    run_op("remneg", OP_REM,  -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1, 0);
    run_op("divu0",  OP_DIVU, 64'h1_2345_6789, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0);
    run_op("remu0",  OP_REMU, 64'h1_2345_6789, 64'd0, 64'h1_2345_6789, 1, 1, 0);
    run_op("divwov", OP_DIVW, 64'h8000_0000, -64'd1, 64'hFFFF_FFFF_8000_0000, 1, 1, 0);
    run_op("divov",  OP_DIV,  64'h8000_0000_0000_0000, -64'd1, 64'h8000_0000_0000_0000, 1, 1, 0);
    run_op("remov",  OP_REM,  64'h8000_0000_0000_0000, -64'd1, 64'd0, 1, 1, 0);
    run_op("divw",   OP_DIVW, 64'd100, -64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 33, 1, 0);
    run_op("remw",   OP_REMW, -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1, 0);
    run_op("remuw",  OP_REMUW, 64'hFFFF_FFFF, 64'd16, 64'd15, 33, 1, 0);
    run_op("divuw",  OP_DIVUW, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, 1, 0);
    run_op("mulhu",  OP_MULHU, -64'd1, -64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1, 0);
    run_op("mul",    OP_MUL,   64'd3, -64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1, 1, 0);
    run_op("mulh",   OP_MULH,  -64'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0);
    run_op("mulhsu", OP_MULHSU, 64'd2, -64'd1, 64'd1, 1, 1, 0);
    run_op("mulw",   OP_MULW,  64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 1, 1, 0);

    // Abort a long division partway through with reset, then divide again.
    @(posedge clk); #1;
    dataD.ctl.op = OP_DIV;
    dataD.srca   = 64'd1000;
    dataD.srcb   = 64'd3;
    all_ready    = 1'b0;
    repeat (32) @(negedge clk);
    check("midop_ready", word_t'(readyE), M_EN ? 64'd0 : 64'd1);
    reset = 1'b1;
    #1;
`ifdef RV64M_EN
    check("midrst_state", word_t'(dut.state), word_t'(IDLE));
    check("midrst_count", word_t'(dut.u_div.count), 64'd0);
`endif
    check("midrst_ready", word_t'(readyE), M_EN ? 64'd0 : 64'd1);
    check("midrst_aluout", dataE.aluout, 64'd0);
    dataD.ctl.op = OP_ADD;
    @(negedge clk);
    reset = 1'b0;
    run_op("div_after_rst", OP_DIV, 64'd9, 64'd3, 64'd3, 65, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk input 1 is the sole clock, and reset input 1 is asynchronous and active-high.
REQ-002 SHALL have port dataD, input, decode_data_t: decoded instruction with ctl, srca, srcb, rd (store data), dst, instr, csr_addr, csr_data.
REQ-003 SHALL have port dataE, output, exec_data_t: ctl, dst, instr, aluout, rd, csr_addr and csr_data, consumed by the memory stage.
REQ-004 SHALL have port readyE, output, 1: result in dataE valid this cycle.
REQ-005 SHALL have port all_ready, input, 1: every stage is ready and the pipeline advances at this edge.

Function
REQ-006 SHALL pass ctl, dst, instr, rd, csr_addr and csr_data from dataD to dataE unchanged and combinationally.
REQ-007 SHALL compute single-cycle ops combinationally: ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU (64-bit, shift amount srcb[5:0]), *W variants (32-bit op on low halves, shift amount srcb[4:0], result sign-extended to 64), and LUI/AUIPC/JAL/JALR/loads/stores as srca+srcb; readyE=1 for these.
REQ-008 SHALL run a FSM with states IDLE, BUSY and DONE; only MUL/MULH/MULHU/MULHSU/MULW/DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW (muldiv ops) leave IDLE.
REQ-009 SHALL, in IDLE with a muldiv op: for a MUL-class op, capture the full product into the result register and go to DONE next edge (latency 1).
REQ-010 SHALL, in IDLE with a DIV/REM-class op and divisor==0, register quotient=all ones (W: sign-extended 32'hFFFFFFFF) and remainder=dividend, then go to DONE (latency 1).
REQ-011 SHALL, in IDLE with signed overflow (dividend=most-negative, divisor=-1, 64- or 32-bit per op), register quotient=dividend and remainder=0, then go to DONE (latency 1).
REQ-012 SHALL, in IDLE with any other division, load div_unit and go to BUSY; BUSY runs one restoring-division iteration per cycle for 64 iterations (32 for W ops), then goes to DONE with the sign-corrected result registered; total latency 65 cycles (33 for W).
REQ-013 SHALL drive readyE=0 in IDLE and BUSY for muldiv ops, and readyE=1 in DONE with aluout taken from the result register.
REQ-014 SHALL return from DONE to IDLE on all_ready=1; all_ready=1 in any state forces IDLE at that edge (the flush abandons the operation).
REQ-015 SHALL ignore changes on dataD while BUSY; the captured operands are authoritative.
REQ-016 SHALL, for MULH/MULHU/MULHSU, deliver the upper 64 bits of the 128-bit signed×signed, unsigned×unsigned or signed×unsigned product; MUL delivers the low 64 bits; MULW delivers the low 32 bits sign-extended.

Reset
REQ-017 SHALL on reset assert: FSM=IDLE, result register=0, iteration counter=0, div_unit registers=0; all asynchronous.
REQ-018 SHALL abort a BUSY division on reset mid-operation with no residual state; the first op after reset behaves as from power-up.

Configuration
REQ-019 SHALL, with RV64M_EN defined, implement REQ-008..REQ-016.
REQ-020 SHALL, with RV64M_EN undefined, omit the FSM, div_unit and multiplier; muldiv ops produce aluout=0 with readyE=1 combinationally.

Structure
REQ-021 SHALL declare decode_data_t, exec_data_t and the op enum (including muldiv ops) in package pipeline, and word_t in package common.
REQ-022 SHALL isolate the iterative divider in sub-module div_unit (ports: clk, reset, start, signed/word flags, a, b, done, quotient, remainder); the multiplier stays inline.

Verification
REQ-023 SHALL cover: ADD srca=5, srcb=-7 -> aluout=64'hFFFFFFFFFFFFFFFE, readyE=1 same cycle.
REQ-024 SHALL cover: DIV 100/7 with all_ready held low -> readyE=0 for 65 cycles, then aluout=14; REM gives 2.
REQ-025 SHALL cover: DIVU x/0 -> DONE after 1 cycle with aluout=all ones; REMU x/0 -> aluout=x.
REQ-026 SHALL cover: DIVW 32'h80000000 / -1 -> aluout=64'hFFFFFFFF80000000 after 1 cycle.
REQ-027 SHALL cover: MULHU all-ones × all-ones -> aluout=64'hFFFFFFFFFFFFFFFE one cycle after issue.
REQ-028 SHALL cover: reset asserted at BUSY iteration 30, then DIV 9/3 -> FSM in IDLE immediately and aluout=3 after 65 cycles.
